// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  // Byte distance between consecutive instruction words.
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // Value driven on instruction_out / PC_out when nothing valid is presented.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // one cycle after reset, before the first request
    S_FETCH = 2'd1,  // request outstanding to instruction memory
    S_DRAIN = 2'd2,  // stale request outstanding after a redirect; data is dropped
    S_HOLD  = 2'd3   // fetched word presented to IF/ID, waiting for acceptance
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches words from instruction
// memory over a req/ready handshake and presents each word with its PC+4 to
// the IF/ID register. All outputs decode registered state only.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   Freeze            IF/ID holding; presented instruction not accepted
//   Branch_taken      redirect from EXE (priority over everything else)
//   Branch_address    redirect target
//   imem_req/addr     fetch request and address (stable while outstanding)
//   imem_ready/rdata  fetch completion and returned word
//   instr_valid       instruction_out / PC_out carry a real instruction
//   instruction_out   fetched word (zero when not valid)
//   PC_out            fetch address + 4 (zero when not valid)
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Freeze,
  input  logic            Branch_taken,
  input  logic [XLEN-1:0] Branch_address,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instruction_out,
  output logic [XLEN-1:0] PC_out
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] next_seq_addr;

  // Sequential successor of the held fetch; wraps modulo 2^32.
  assign next_seq_addr = addr_q + PC_STEP;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

  // Next-state and register-update logic; Branch_taken dominates in every state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (Branch_taken) begin
          pc_d   = Branch_address;
          addr_d = Branch_address;
        end else begin
          addr_d = pc_q;
        end
      end

      S_FETCH: begin
        if (imem_ready) begin
          if (Branch_taken) begin
            // Returned word belongs to the wrong path; refetch at the target.
            pc_d   = Branch_address;
            addr_d = Branch_address;
          end else begin
            instr_d = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (Branch_taken) begin
          // Request cannot be withdrawn; remember the target and drain.
          pc_d    = Branch_address;
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // Later redirects overwrite pc_q; the most recent one wins.
        if (Branch_taken) begin
          pc_d = Branch_address;
        end
        if (imem_ready) begin
          addr_d  = Branch_taken ? Branch_address : pc_q;
          state_d = S_FETCH;
        end
      end

      S_HOLD: begin
        if (Branch_taken) begin
          pc_d    = Branch_address;
          addr_d  = Branch_address;
          state_d = S_FETCH;
        end else if (!Freeze) begin
          pc_d    = next_seq_addr;
          addr_d  = next_seq_addr;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    imem_req        = 1'b0;
    imem_addr       = addr_q;
    instr_valid     = 1'b0;
    instruction_out = NOP_INSTR;
    PC_out          = NOP_INSTR;

    unique case (state_q)
      S_FETCH, S_DRAIN: imem_req = 1'b1;
      S_HOLD: begin
        instr_valid     = 1'b1;
        instruction_out = instr_q;
        PC_out          = next_seq_addr;
      end
      default: ;
    endcase
  end

endmodule
